tdm_demux8: RTL

- 1:8 time-division demultiplexer, the receive end of a serial 8-slot TDM link.
- Accepts one sample per valid cycle plus a frame-sync marker on slot 0.
- Rebuilds the 8 channel values and presents them as a registered parallel word, one update per complete frame.
- Sits after the serial link, feeding parallel consumers (e.g. boolean-function evaluators that take channel bits as inputs).

---
 rtl/tdm_demux8_if.sv | 37 +++
 rtl/tdm_demux8.sv | 121 ++++++++++++
 2 files changed

// File: rtl/tdm_demux8_if.sv
// Bus bundle for the 8-slot TDM receive demultiplexer.
// master: serial link side (drives din/din_valid/frame_sync, observes results)
// slave : demultiplexer side (consumes serial samples, drives parallel word and status)
//   din        serial sample for the current slot
//   din_valid  din is valid this cycle
//   frame_sync marks din as slot 0 (qualified by din_valid)
//   ch         last complete frame, slot k at ch[k*WIDTH +: WIDTH]
//   frame_done one-cycle pulse when ch updates
//   locked     aligned to the frame
//   slot       slot index the next valid sample will occupy
//   sync_err   one-cycle pulse on alignment error
//   frame_cnt  completed frames, wrapping
interface tdm_demux8_if #(
   parameter int unsigned WIDTH = 1
);
   localparam int unsigned NSLOT = 8;

   logic [WIDTH-1:0]       din;
   logic                   din_valid;
   logic                   frame_sync;
   logic [NSLOT*WIDTH-1:0] ch;
   logic                   frame_done;
   logic                   locked;
   logic [2:0]             slot;
   logic                   sync_err;
   logic [7:0]             frame_cnt;

   modport master (
      output din, din_valid, frame_sync,
      input  ch, frame_done, locked, slot, sync_err, frame_cnt
   );

   modport slave (
      input  din, din_valid, frame_sync,
      output ch, frame_done, locked, slot, sync_err, frame_cnt
   );
endinterface

// File: rtl/tdm_demux8.sv
// 1:8 time-division demultiplexer: receive end of a serial 8-slot TDM link.
// Collects one sample per valid cycle into a shadow register and publishes the
// whole frame on ch one clock after the slot-7 sample. Aligns on frame_sync.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high
//   bus  tdm_demux8_if.slave (din, din_valid, frame_sync in;
//        ch, frame_done, locked, slot, sync_err, frame_cnt out)
// Parameters:
//   WIDTH        bits per channel sample
//   SYNC_STRICT  1: missing frame_sync at slot 0 while locked drops lock
module tdm_demux8 #(
   parameter int unsigned WIDTH       = 1,
   parameter int unsigned SYNC_STRICT = 1
) (
   input  logic         clk,
   input  logic         rst,
   tdm_demux8_if.slave  bus
);
   localparam int unsigned NSLOT   = 8;
   localparam int unsigned NSHADOW = NSLOT - 1;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [2:0]             slot_q, slot_d;
   // slot 7 never needs storage: it goes straight from din into ch
   logic [WIDTH-1:0]       shadow_q [NSHADOW];
   logic [WIDTH-1:0]       shadow_d [NSHADOW];
   logic [NSLOT*WIDTH-1:0] ch_q, ch_d;
   logic                   frame_done_q, frame_done_d;
   logic                   sync_err_q, sync_err_d;
   logic                   locked_q;
   logic [7:0]             frame_cnt_q, frame_cnt_d;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HUNT;
         slot_q       <= 3'd0;
         ch_q         <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
         locked_q     <= 1'b0;
         frame_cnt_q  <= 8'd0;
         for (int unsigned k = 0; k < NSHADOW; k++) begin
            shadow_q[k] <= '0;
         end
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         ch_q         <= ch_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
         locked_q     <= (state_d == LOCKED);
         frame_cnt_q  <= frame_cnt_d;
         shadow_q     <= shadow_d;
      end
   end

   // Next-state, shadow capture and frame publication
   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      shadow_d     = shadow_q;
      ch_d         = ch_q;
      frame_cnt_d  = frame_cnt_q;
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;

      if (bus.din_valid) begin
         case (state_q)
            HUNT: begin
               if (bus.frame_sync) begin
                  shadow_d[0] = bus.din;
                  slot_d      = 3'd1;
                  state_d     = LOCKED;
               end
            end
            LOCKED: begin
               if (slot_q == 3'd0) begin
                  if (bus.frame_sync || (SYNC_STRICT == 0)) begin
                     shadow_d[0] = bus.din;
                     slot_d      = 3'd1;
                  end else begin
                     sync_err_d = 1'b1;
                     state_d    = HUNT;
                     slot_d     = 3'd0;
                  end
               end else if (bus.frame_sync) begin
                  // early sync: abandon partial frame, realign on this sample
                  sync_err_d  = 1'b1;
                  shadow_d[0] = bus.din;
                  slot_d      = 3'd1;
               end else if (slot_q == 3'd7) begin
                  for (int unsigned k = 0; k < NSHADOW; k++) begin
                     ch_d[k*WIDTH +: WIDTH] = shadow_q[k];
                  end
                  ch_d[NSHADOW*WIDTH +: WIDTH] = bus.din;
                  frame_done_d = 1'b1;
                  frame_cnt_d  = frame_cnt_q + 8'd1;
                  slot_d       = 3'd0;
               end else begin
                  shadow_d[slot_q] = bus.din;
                  slot_d           = slot_q + 3'd1;
               end
            end
         endcase
      end
   end

   assign bus.ch         = ch_q;
   assign bus.frame_done = frame_done_q;
   assign bus.locked     = locked_q;
   assign bus.slot       = slot_q;
   assign bus.sync_err   = sync_err_q;
   assign bus.frame_cnt  = frame_cnt_q;
endmodule
